// File: rtl/vga_pkg.sv
// Shared video-RAM types: default bus widths and the queued write record.
package vga_pkg;

    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 8;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Write queue for the video-RAM arbiter: synchronous FIFO of wr_entry_t records.
module vram_wr_fifo
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1,
    localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wr_entry_t        push_entry,
    input  logic             pop,
    output wr_entry_t        head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    wr_entry_t        slots [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = slots[rptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop_ok)  rptr <= rptr + PTR_W'(1);
            level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) slots[wptr] <= push_entry;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter: display reads always win, queued drawing
// writes fill the cycles without a display read.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              busy
);

    wr_entry_t push_entry;
    wr_entry_t head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      ready_en;
    logic      vld_p1;
    logic      vld_p2;

    assign push_entry = '{addr: wr_addr, data: wr_data};
    assign push       = wr_valid && wr_ready;
    assign pop        = mem_en && mem_we;

    vram_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .level      (fifo_level),
        .full       (full),
        .empty      (empty)
    );

    // Ready depends only on registered state, so it cannot see this cycle's pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign wr_ready = ready_en && !full;
    assign busy     = (fifo_level != '0);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset && disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (reset && !empty) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end
    end

    // Stage p1: RAM is returning data for last cycle's read.
    // Stage p2: captured read data presented to scanout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            disp_data <= '0;
        end else begin
            vld_p1 <= disp_req;
            vld_p2 <= vld_p1;
            if (vld_p1) disp_data <= mem_rdata;
        end
    end

    assign disp_valid = vld_p2;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vectors, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_vram_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [LW-1:0] fifo_level;
    logic          busy;

    always #20 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: accepted writes as a queue, RAM contents as an array,
    // display results as a one-deep delay line.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { bit v; logic [DW-1:0] d; } rd_t;
    wr_t           q[$];
    rd_t           pipe[$];
    logic [DW-1:0] gold [0:(1<<AW)-1];
    bit            started;
    bit            cur_v;
    logic [DW-1:0] cur_d;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        pipe.delete();
        pipe.push_back('{v: 1'b0, d: 8'h00});
        cur_v   = 1'b0;
        cur_d   = '0;
        started = 1'b0;
    endtask

    task automatic m_check();
        bit            e_en;
        bit            e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        e_en = 0; e_we = 0; e_a = '0; e_d = '0;
        if (!reset) m_reset();
        else if (disp_req) begin
            e_en = 1; e_a = disp_addr;
        end else if (q.size() > 0) begin
            e_en = 1; e_we = 1; e_a = q[0].a; e_d = q[0].d;
        end
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_a);
        if (!(e_en && !e_we)) chk("mem_wdata", mem_wdata, e_d);
        chk("wr_ready", wr_ready, started && (q.size() < DEPTH));
        chk("fifo_level", fifo_level, q.size());
        chk("busy", busy, q.size() != 0);
        chk("disp_valid", disp_valid, cur_v);
        chk("disp_data", disp_data, cur_d);
    endtask

    task automatic m_advance();
        rd_t e;
        bit  acc;
        if (!reset) begin
            m_reset();
            return;
        end
        acc = started && wr_valid && (q.size() < DEPTH);
        e.v = disp_req;
        e.d = gold[disp_addr];
        pipe.push_back(e);
        e = pipe.pop_front();
        cur_v = e.v;
        if (e.v) cur_d = e.d;
        if (!disp_req && q.size() > 0) begin
            gold[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (acc) q.push_back('{a: wr_addr, d: wr_data});
        started = 1'b1;
    endtask

    task automatic drive(input bit dr, input logic [AW-1:0] da, input bit wv,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        disp_req  = dr;
        disp_addr = da;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
    endtask

    task automatic tick_check();
        @(negedge clk);
        m_check();
    endtask

    task automatic tick_end();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit dr, input logic [AW-1:0] da, input bit wv,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        drive(dr, da, wv, wa, wd);
        tick_check();
        tick_end();
    endtask

    typedef struct {
        bit dr; logic [AW-1:0] da; bit wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
        bit en; bit we; logic [AW-1:0] ma; logic [DW-1:0] md; int lvl; bit rdy; bit dv;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int            k;
        int            nvalid;
        int            nwe;
        int            first_v;
        int            nwr;
        int            maxlvl;
        logic [AW-1:0] waddr [6];
        int            wcyc  [6];
        bit            rdy0;
        bit            rdy1;
        bit            pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]  = i[7:0];
            gold[i] = i[7:0];
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        m_reset();
        @(posedge clk);
        #1;

        // Reset held with a write offered: nothing queued, ready low.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 17'h00033, 8'h77);
        drive(0, 0, 1, 17'h00033, 8'h77);
        tick_check();
        chk("reset_level", fifo_level, 0);
        chk("reset_ready", wr_ready, 0);
        chk("reset_mem_en", mem_en, 0);
        tick_end();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick_check();
        chk("release_ready_before_edge", wr_ready, 0);
        tick_end();
        drive(0, 0, 0, 0, 0);
        tick_check();
        chk("release_ready_after_edge", wr_ready, 1);
        tick_end();

        tbl[0] = '{0, 17'h0,  1, 17'h10, 8'hA5, 0, 0, 17'h0,  8'h00, 0, 1, 0};
        tbl[1] = '{0, 17'h0,  0, 17'h0,  8'h00, 1, 1, 17'h10, 8'hA5, 1, 1, 0};
        tbl[2] = '{0, 17'h0,  0, 17'h0,  8'h00, 0, 0, 17'h0,  8'h00, 0, 1, 0};
        tbl[3] = '{1, 17'h7,  1, 17'h20, 8'h11, 1, 0, 17'h7,  8'h00, 0, 1, 0};
        tbl[4] = '{1, 17'h8,  1, 17'h21, 8'h22, 1, 0, 17'h8,  8'h00, 1, 1, 0};
        tbl[5] = '{0, 17'h0,  0, 17'h0,  8'h00, 1, 1, 17'h20, 8'h11, 2, 1, 1};
        tbl[6] = '{0, 17'h0,  0, 17'h0,  8'h00, 1, 1, 17'h21, 8'h22, 1, 1, 1};
        tbl[7] = '{0, 17'h0,  0, 17'h0,  8'h00, 0, 0, 17'h0,  8'h00, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].dr, tbl[i].da, tbl[i].wv, tbl[i].wa, tbl[i].wd);
            tick_check();
            chk($sformatf("vec%0d_en", i), mem_en, tbl[i].en);
            chk($sformatf("vec%0d_we", i), mem_we, tbl[i].we);
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].ma);
            if (tbl[i].we) chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].md);
            chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl);
            chk($sformatf("vec%0d_ready", i), wr_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_dvalid", i), disp_valid, tbl[i].dv);
            tick_end();
        end

        // Scanout burst of 640 reads.
        nvalid = 0; nwe = 0; first_v = -1;
        for (int i = 0; i < 642; i++) begin
            drive(i < 640, (i < 640) ? i : 0, 0, 0, 0);
            tick_check();
            if (disp_valid) begin
                nvalid++;
                if (first_v < 0) first_v = i;
            end
            if (mem_we) nwe++;
            tick_end();
        end
        chk("pipe_valid_count", nvalid, 640);
        chk("pipe_first_valid", first_v, 2);
        chk("pipe_no_write", nwe, 0);

        // Back-pressure while the display owns every cycle.
        k = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 17'h200, k < 6, 17'h40 + k, 8'hC0 + k);
            tick_check();
            if (wr_valid && wr_ready) k++;
            tick_end();
        end
        drive(1, 17'h200, 1, 17'h40 + k, 8'hC0 + k);
        tick_check();
        chk("bp_accepted", k, 4);
        chk("bp_level", fifo_level, 4);
        chk("bp_ready", wr_ready, 0);
        tick_end();
        nwr = 0; maxlvl = 0; rdy0 = 1; rdy1 = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, k < 6, 17'h40 + k, 8'hC0 + k);
            tick_check();
            if (i == 0) rdy0 = wr_ready;
            if (i == 1) rdy1 = wr_ready;
            if (int'(fifo_level) > maxlvl) maxlvl = fifo_level;
            if (mem_we && nwr < 6) begin
                waddr[nwr] = mem_addr;
                wcyc[nwr]  = i;
                nwr++;
            end
            if (wr_valid && wr_ready) k++;
            tick_end();
        end
        chk("pp_ready_on_pop", rdy0, 0);
        chk("pp_ready_next", rdy1, 1);
        chk("pp_max_level", maxlvl, 4);
        chk("bp_write_count", nwr, 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("bp_order%0d", j), waddr[j], 17'h40 + j);
            chk($sformatf("bp_cycle%0d", j), wcyc[j], j);
        end

        // Read of an address whose write is still queued returns old data.
        cycle(1, 17'h5, 1, 17'h5, 8'h3C);
        cycle(1, 17'h5, 0, 0, 0);
        drive(1, 17'h5, 0, 0, 0);
        tick_check();
        chk("raw_old_valid", disp_valid, 1);
        chk("raw_old_data", disp_data, 8'h05);
        chk("raw_queued", fifo_level, 1);
        tick_end();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 17'h5, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick_check();
        chk("raw_new_valid", disp_valid, 1);
        chk("raw_new_data", disp_data, 8'h3C);
        tick_end();

        // Reset mid-operation, between clock edges.
        for (int i = 0; i < 3; i++) cycle(1, 17'h9, 1, 17'h60 + i, 8'h90 + i);
        drive(1, 17'h9, 1, 17'h70, 8'h55);
        reset = 1'b0;
        #1;
        chk("async_dvalid", disp_valid, 0);
        chk("async_level", fifo_level, 0);
        chk("async_busy", busy, 0);
        chk("async_mem_en", mem_en, 0);
        tick_check();
        tick_end();
        cycle(1, 17'h9, 0, 0, 0);
        reset = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Random traffic: heavy display load, then light; client holds offers.
        pend = 0; pa = '0; pd = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend && ($urandom_range(0, 99) < 50)) begin
                pend = 1;
                pa   = 17'($urandom_range(0, 15));
                pd   = 8'($urandom_range(0, 255));
            end
            drive($urandom_range(0, 99) < ((i < 1000) ? 80 : 30),
                  17'($urandom_range(0, 15)), pend, pa, pd);
            tick_check();
            if (wr_valid && wr_ready) pend = 0;
            tick_end();
        end
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick_check();
        chk("final_drained", fifo_level, 0);
        tick_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
